// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide issue/writeback controller.
package multdiv_pkg;

  // Controller states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StBusy  = 2'd2,
    StDone  = 2'd3
  } md_state_e;

  // Operation encoding carried on issue_op
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Defaults for the top-level parameters
  localparam int unsigned TIMEOUT_CYCLES_DEF = 40;
  localparam logic [4:0]  EXC_REG_DEF        = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE_DEF  = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE_DEF   = 32'd5;

  // Status code written to the exception register for a given opcode
  function automatic logic [31:0] exc_code(input logic op, input logic [31:0] mult_code,
                                           input logic [31:0] div_code);
    return (op == OP_DIV) ? div_code : mult_code;
  endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Saturating BUSY-cycle counter with synchronous clear and terminal-count flag.
module md_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CntTerm = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  // Count enabled cycles; hold at the maximum instead of wrapping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != CntMax)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == CntTerm);

endmodule

// File: rtl/multdiv_ctrl.sv
// Issue/writeback controller for the shared multiply/divide unit.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [4:0]  EXC_REG        = EXC_REG_DEF,
  parameter logic [31:0] MULT_EXC_CODE  = MULT_EXC_CODE_DEF,
  parameter logic [31:0] DIV_EXC_CODE   = DIV_EXC_CODE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_op,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [4:0]  issue_rd,
  input  logic        flush,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  md_state_e        state_q, state_d;
  logic             op_q;
  logic [31:0]      a_q, b_q;
  logic [4:0]       rd_q;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             mult_q, mult_d, div_q, div_d;
  logic             latch_en, cap_en, cap_exc;
  logic             cnt_clear, cnt_en, cnt_term;
  logic [CNT_W-1:0] cnt;

  md_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .count    (cnt),
    .terminal (cnt_term)
  );

  // Next-state decode, operand latch and writeback capture strobes
  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    cap_en    = 1'b0;
    cap_exc   = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      StIdle: begin
        if (issue_valid) begin
          state_d  = StStart;
          latch_en = 1'b1;
        end
      end
      StStart: begin
        cnt_clear = 1'b1;
        state_d   = StBusy;
      end
      StBusy: begin
        cnt_en = 1'b1;
        // A ready seen with count 0 may be left over from the previous op
        if (md_ready && (cnt != '0)) begin
          cap_en  = 1'b1;
          cap_exc = md_exception;
          state_d = StDone;
        end else if (cnt_term) begin
          cap_en  = 1'b1;
          cap_exc = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (wb_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Flush wins over everything; stall is 0 under flush, so an issue seen then is dropped
    if (flush) begin
      state_d  = StIdle;
      latch_en = 1'b0;
      cap_en   = 1'b0;
    end
  end

  // Start pulses are decoded from the next state so they come straight from flops
  always_comb begin
    mult_d    = (state_d == StStart) && (issue_op == OP_MULT);
    div_d     = (state_d == StStart) && (issue_op == OP_DIV);
    wb_rd_d   = cap_exc ? EXC_REG : rd_q;
    wb_data_d = cap_exc ? exc_code(op_q, MULT_EXC_CODE, DIV_EXC_CODE) : md_result;
  end

  // State register and start pulse flops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      mult_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mult_q  <= mult_d;
      div_q   <= div_d;
    end
  end

  // Request latch: held from START until the controller is back in IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q <= OP_MULT;
      a_q  <= '0;
      b_q  <= '0;
      rd_q <= '0;
    end else if (latch_en) begin
      op_q <= issue_op;
      a_q  <= issue_a;
      b_q  <= issue_b;
      rd_q <= issue_rd;
    end
  end

  // Writeback registers: loaded once when leaving BUSY, stable through DONE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else if (cap_en) begin
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Pipeline hold request
  always_comb begin
    stall = 1'b0;
    if (!flush) begin
      case (state_q)
        StIdle:  stall = issue_valid;
        StStart: stall = 1'b1;
        StBusy:  stall = 1'b1;
        StDone:  stall = ~wb_ack;
        default: stall = 1'b0;
      endcase
    end
  end

  assign md_ctrl_mult = mult_q;
  assign md_ctrl_div  = div_q;
  assign md_operand_a = a_q;
  assign md_operand_b = b_q;
  assign wb_valid     = (state_q == StDone);
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed table, flush/reset sequences, random ops.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_op = 1'b0;
  logic [31:0] issue_a = '0;
  logic [31:0] issue_b = '0;
  logic [4:0]  issue_rd = '0;
  logic        flush = 1'b0;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_operand_a, md_operand_b;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_ready = 1'b0;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ack = 1'b0;

  int errors = 0;
  int checks = 0;

  multdiv_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_op     (issue_op),
    .issue_a      (issue_a),
    .issue_b      (issue_b),
    .issue_rd     (issue_rd),
    .flush        (flush),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_operand_a (md_operand_a),
    .md_operand_b (md_operand_b),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_ready     (md_ready),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_ack       (wb_ack)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b, stall, wb_valid,
                 wb_rd, wb_data}, '0);
  endtask

  // Behaviour of the arithmetic unit: 32-bit unsigned product/quotient with error flags
  function automatic void unit_model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output logic exc);
    logic [63:0] p;
    if (op == 1'b0) begin
      p   = {32'd0, a} * {32'd0, b};
      res = p[31:0];
      exc = |p[63:32];
    end else begin
      exc = (b == 32'd0);
      res = exc ? 32'd0 : a / b;
    end
  endfunction

  // Expected writeback. Ready first raised (or held) on cycle lat after the start cycle;
  // it only counts from the second BUSY cycle (index 2), and 40 BUSY cycles is the limit.
  function automatic void wb_model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] rd, input int lat,
                                   output logic [4:0] erd, output logic [31:0] edata,
                                   output int ek);
    logic [31:0] res;
    logic        exc;
    int          kr;
    unit_model(op, a, b, res, exc);
    kr = (lat < 2) ? 2 : lat;
    if (kr <= 40) begin
      ek = kr + 1;
    end else begin
      ek  = 41;
      exc = 1'b1;
    end
    erd   = exc ? 5'd30 : rd;
    edata = exc ? (op ? 32'd5 : 32'd4) : res;
  endfunction

  // Unit response for the cycle k after issue (k=0 is the start cycle)
  task automatic drive_unit(input int k, input int lat, input logic [31:0] res, input logic exc);
    if (lat < 2 && k < 2) begin
      md_ready     = 1'b1;
      md_result    = $urandom;
      md_exception = 1'($urandom);
    end else if (k < lat) begin
      md_ready     = 1'b0;
      md_result    = $urandom;
      md_exception = 1'($urandom);
    end else begin
      md_ready     = 1'b1;
      md_result    = res;
      md_exception = exc;
    end
  endtask

  // One full transaction, entered and left on a falling edge with the DUT idle
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input int hold, input logic b2b,
                        input logic [4:0] exp_rd, input logic [31:0] exp_data, input int exp_k);
    logic [31:0] res;
    logic        exc;
    int          done_k;
    int          extra;
    logic        stall_low;
    unit_model(op, a, b, res, exc);
    done_k    = -1;
    extra     = 0;
    stall_low = 1'b0;
    issue_valid = 1'b1;
    issue_op    = op;
    issue_a     = a;
    issue_b     = b;
    issue_rd    = rd;
    #1 check("stall_issue", stall, 1'b1);
    @(negedge clock);
    issue_valid = 1'b0;
    issue_op    = 1'($urandom);
    issue_a     = $urandom;
    issue_b     = $urandom;
    issue_rd    = 5'($urandom);
    check("start_pulse", {md_ctrl_mult, md_ctrl_div}, op ? 2'b01 : 2'b10);
    check("operands", {md_operand_a, md_operand_b}, {a, b});
    if (!stall) stall_low = 1'b1;
    drive_unit(0, lat, res, exc);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (wb_valid) begin
        done_k = k;
        break;
      end
      if (md_ctrl_mult || md_ctrl_div) extra++;
      if (!stall) stall_low = 1'b1;
      drive_unit(k, lat, res, exc);
    end
    check("latency", done_k, exp_k);
    check("extra_pulse", extra, 0);
    check("stall_busy", stall_low, 1'b0);
    check("wb_rd", wb_rd, exp_rd);
    check("wb_data", wb_data, exp_data);
    md_exception = 1'b0;
    md_result    = $urandom;
    for (int h = 0; h < hold; h++) begin
      md_ready = 1'($urandom);
      check("stall_done", stall, 1'b1);
      @(negedge clock);
      check("wb_hold", {wb_valid, wb_rd, wb_data}, {1'b1, exp_rd, exp_data});
    end
    md_ready    = 1'b0;
    wb_ack      = 1'b1;
    issue_valid = b2b;
    #1 check("stall_ack", stall, 1'b0);
    @(negedge clock);
    wb_ack = 1'b0;
    check("idle_after_ack", {wb_valid, md_ctrl_mult, md_ctrl_div}, 3'b000);
    if (b2b) check("b2b_stall", stall, 1'b1);
  endtask

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          lat;
    int          hold;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    int          exp_k;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [4:0]  erd;
    logic [31:0] edata;
    logic        acc;
    int          ek;
    logic        rop;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;
    int          rlat;

    vecs[0] = '{1'b0, 32'd7,          32'd6,  5'd3,  17, 10, 5'd3,  32'd42, 18};
    vecs[1] = '{1'b1, 32'd100,        32'd0,  5'd9,  5,  1,  5'd30, 32'd5,  6};
    vecs[2] = '{1'b0, 32'h4000_0000,  32'd4,  5'd7,  3,  0,  5'd30, 32'd4,  4};
    vecs[3] = '{1'b1, 32'd100,        32'd7,  5'd12, 0,  2,  5'd12, 32'd14, 3};
    vecs[4] = '{1'b0, 32'd3,          32'd5,  5'd1,  60, 0,  5'd30, 32'd4,  41};
    vecs[5] = '{1'b1, 32'd50,         32'd5,  5'd2,  60, 1,  5'd30, 32'd5,  41};
    vecs[6] = '{1'b1, 32'd9,          32'd3,  5'd4,  40, 0,  5'd4,  32'd3,  41};
    vecs[7] = '{1'b0, 32'd2,          32'd3,  5'd31, 2,  3,  5'd31, 32'd6,  3};

    repeat (2) @(negedge clock);
    check_reset_vals("reset_vals");
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals("idle_after_reset");

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].lat, vecs[i].hold, 1'b1,
             vecs[i].exp_rd, vecs[i].exp_data, vecs[i].exp_k);
    end

    // Flush in the fifth BUSY cycle, then a late ready: nothing may be written back
    issue_valid = 1'b1;
    issue_op    = 1'b1;
    issue_a     = 32'd100;
    issue_b     = 32'd5;
    issue_rd    = 5'd6;
    md_ready    = 1'b0;
    @(negedge clock);
    issue_valid = 1'b0;
    repeat (5) @(negedge clock);
    check("flush_pre", wb_valid, 1'b0);
    flush        = 1'b1;
    md_ready     = 1'b1;
    md_result    = 32'd20;
    md_exception = 1'b0;
    #1 check("stall_flush", stall, 1'b0);
    @(negedge clock);
    flush = 1'b0;
    acc   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      acc = acc | wb_valid | md_ctrl_mult | md_ctrl_div | stall;
      @(negedge clock);
    end
    check("flush_quiet", acc, 1'b0);
    md_ready = 1'b0;
    run_op(1'b0, 32'd11, 32'd3, 5'd5, 4, 1, 1'b1, 5'd5, 32'd33, 5);

    // Asynchronous reset in the middle of BUSY
    issue_op = 1'b0;
    issue_a  = 32'd3;
    issue_b  = 32'd4;
    issue_rd = 5'd8;
    @(negedge clock);
    issue_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1 check_reset_vals("reset_mid");
    @(negedge clock);
    check_reset_vals("reset_hold");
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_vals("post_reset_idle");
    wb_model(1'b1, 32'd81, 32'd9, 5'd10, 6, erd, edata, ek);
    run_op(1'b1, 32'd81, 32'd9, 5'd10, 6, 2, 1'b1, erd, edata, ek);

    // Randomized operations against the model
    for (int i = 0; i < 30; i++) begin
      rop  = 1'($urandom);
      ra   = $urandom;
      case ($urandom % 4)
        0:       rb = 32'd0;
        1:       rb = $urandom;
        default: rb = $urandom % 1000;
      endcase
      rrd  = 5'($urandom);
      rlat = $urandom_range(0, 45);
      wb_model(rop, ra, rb, rrd, rlat, erd, edata, ek);
      run_op(rop, ra, rb, rrd, rlat, $urandom_range(0, 3), (i != 29) && 1'($urandom),
             erd, edata, ek);
    end
    issue_valid = 1'b0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Issue/writeback controller for the shared multiply/divide unit in the execute stage. Accepts one MULT or DIV request from the pipeline, latches operands and destination register, pulses the unit's start control for exactly one cycle, stalls the pipeline until the unit reports ready (or a timeout expires), then presents a single writeback. An arithmetic exception is redirected to the status register with an opcode-specific code.

## Interface
Parameters:
- TIMEOUT_CYCLES, 40: BUSY cycles allowed before a forced abort.
- EXC_REG, 30: destination register used on exception.
- MULT_EXC_CODE, 4: writeback data on MULT exception.
- DIV_EXC_CODE, 5: writeback data on DIV exception.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- issue_valid  in  1  request present; sampled only in IDLE.
- issue_op  in  1  0 = MULT, 1 = DIV.
- issue_a, issue_b  in  32  operands.
- issue_rd  in  5  destination register.
- flush  in  1  squash in-flight operation.
- md_ctrl_mult, md_ctrl_div  out  1  one-cycle start pulses to the unit.
- md_operand_a, md_operand_b  out  32  latched operands, stable from START until return to IDLE.
- md_result  in  32; md_exception  in  1; md_ready  in  1  unit outputs.
- stall  out  1  hold upstream stages.
- wb_valid  out  1; wb_rd  out  5; wb_data  out  32  writeback request.
- wb_ack  in  1  writeback accepted.

## Operation
- States: IDLE, START, BUSY, DONE (encoding from the shared package).
- IDLE: on issue_valid, latch op/a/b/rd, go to START. Otherwise stay.
- START: assert md_ctrl_mult (op=0) or md_ctrl_div (op=1) for this cycle only; clear counter; go to BUSY.
- BUSY: counter increments each cycle. md_ready is ignored in the first BUSY cycle (counter==0), so a stale ready from a prior op is never taken. On md_ready with counter ≥ 1: capture result/exception into writeback registers and go to DONE. On counter == TIMEOUT_CYCLES-1 without ready: go to DONE with exception forced.
- Writeback on no exception: wb_rd = latched rd, wb_data = md_result. On exception: wb_rd = EXC_REG, wb_data = MULT_EXC_CODE or DIV_EXC_CODE per latched op.
- DONE: wb_valid=1 with stable wb_rd/wb_data; on wb_ack go to IDLE.
- flush: in START/BUSY/DONE returns to IDLE next edge, no writeback, no start pulse issued afterwards; takes priority over md_ready, timeout and wb_ack. Unit left running; its result is discarded (a later START restarts it).
- stall = (IDLE & issue_valid) | (START | BUSY) | (DONE & ~wb_ack). Forced 0 when flush is high.
- issue_valid outside IDLE is ignored.
- Counter width: $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.

## Timing
- Reset values: state IDLE, md_ctrl_mult=0, md_ctrl_div=0, md_operand_a/b=0, stall=0, wb_valid=0, wb_rd=0, wb_data=0, counter=0.
- Reset mid-operation: immediate return to IDLE, no pulse, no writeback.
- Issue at edge N → START during N+1 (pulse visible) → BUSY from N+2.
- md_ready sampled at edge M (in BUSY, counter≥1) → wb_valid high from M+1.
- Total latency issue→wb_valid = unit latency + 3 cycles minimum.
- Back-to-back: wb_ack and new issue_valid in the same cycle: ack handled, new issue accepted no earlier than the following IDLE cycle.
- Start pulses are registered outputs, never combinational from issue_valid.

## Structure
- Shared package multdiv_pkg: state enum, op encoding (OP_MULT=0, OP_DIV=1), exception codes, EXC_REG default.
- One natural sub-module: md_timeout_counter (enable, clear, saturate, terminal-count output).
- Top-level hookup instantiates this controller beside the multdiv unit; controller owns all unit control inputs.

## Test plan
- MULT 7×6, rd=3, unit ready after 17 cycles → one md_ctrl_mult pulse, stall high throughout, wb_valid with wb_rd=3, wb_data=42, then IDLE after wb_ack.
- DIV 100÷0, rd=9, md_exception=1 → wb_rd=30, wb_data=5; MULT overflow (0x40000000×4) → wb_rd=30, wb_data=4.
- md_ready held high from prior op, new DIV issued → stale ready ignored in first BUSY cycle; writeback only after fresh ready.
- No md_ready for 40 BUSY cycles → DONE at cycle 40 with wb_rd=30, wb_data per op.
- flush during BUSY cycle 5, then md_ready → no wb_valid, stall drops, next issue pulses start again.
- reset asserted mid-BUSY and wb_ack withheld in DONE for 10 cycles → all outputs return to reset values immediately; wb_valid/wb_data stable across withheld-ack cycles.
